// File: rtl/uart_msg_arbiter.sv
// rtl/uart_msg_arbiter.sv - round-robin arbiter framing mode/direction messages onto one UART TX byte stream
module uart_msg_arbiter #(
  parameter logic [7:0] HDR_MODE = 8'hA1,
  parameter logic [7:0] HDR_DIR  = 8'hA2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_req,
  input  logic [7:0] mode_data,
  output logic       mode_ack,
  input  logic       dir_req,
  input  logic [7:0] dir_data,
  output logic       dir_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;
  typedef enum logic {GNT_MODE, GNT_DIR} grant_t;

  state_t     state, state_n;
  grant_t     last_grant, last_grant_n;
  grant_t     cur_grant, cur_grant_n;
  logic [7:0] pay_q, pay_n;
  logic [7:0] chk_q, chk_n;
  logic [7:0] tx_data_n, frames_n;
  logic       tx_valid_n, mode_ack_n, dir_ack_n, busy_n;
  logic       xfer, pick_mode, pick_dir;
  logic [7:0] hdr_sel, data_sel;

  assign xfer      = tx_valid && tx_ready;
  // MODE wins unless DIR is also pending and MODE was served last
  assign pick_mode = mode_req && (!dir_req || (last_grant == GNT_DIR));
  assign pick_dir  = dir_req && !pick_mode;
  assign hdr_sel   = pick_mode ? HDR_MODE : HDR_DIR;
  assign data_sel  = pick_mode ? mode_data : dir_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GNT_DIR;
      cur_grant   <= GNT_DIR;
      pay_q       <= 8'h00;
      chk_q       <= 8'h00;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      mode_ack    <= 1'b0;
      dir_ack     <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= 8'h00;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      cur_grant   <= cur_grant_n;
      pay_q       <= pay_n;
      chk_q       <= chk_n;
      tx_data     <= tx_data_n;
      tx_valid    <= tx_valid_n;
      mode_ack    <= mode_ack_n;
      dir_ack     <= dir_ack_n;
      busy        <= busy_n;
      frames_sent <= frames_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cur_grant_n  = cur_grant;
    pay_n        = pay_q;
    chk_n        = chk_q;
    tx_data_n    = tx_data;
    tx_valid_n   = tx_valid;
    frames_n     = frames_sent;
    mode_ack_n   = 1'b0;
    dir_ack_n    = 1'b0;

    case (state)
      IDLE: begin
        tx_valid_n = 1'b0;
        if (pick_mode || pick_dir) begin
          cur_grant_n = pick_mode ? GNT_MODE : GNT_DIR;
          pay_n       = data_sel;
          chk_n       = hdr_sel ^ data_sel;
          tx_data_n   = hdr_sel;
          tx_valid_n  = 1'b1;
          mode_ack_n  = pick_mode;
          dir_ack_n   = pick_dir;
          state_n     = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          tx_data_n = pay_q;
          state_n   = PAY;
        end
      end
      PAY: begin
        if (xfer) begin
          tx_data_n = chk_q;
          state_n   = CHK;
        end
      end
      CHK: begin
        if (xfer) begin
          tx_valid_n   = 1'b0;
          frames_n     = frames_sent + 8'd1;
          last_grant_n = cur_grant;
          state_n      = IDLE;
        end
      end
      default: begin
        tx_valid_n = 1'b0;
        state_n    = IDLE;
      end
    endcase

    // busy tracks the registered state so it is high exactly while a frame is in flight
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// tb/tb_uart_msg_arbiter.sv - self-checking bench for uart_msg_arbiter against a frame-level queue model
module tb_uart_msg_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_req = 1'b0;
  logic [7:0] mode_data = 8'h00;
  logic       mode_ack;
  logic       dir_req = 1'b0;
  logic [7:0] dir_data = 8'h00;
  logic       dir_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic [7:0] frames_sent;

  uart_msg_arbiter dut (
    .clk(clk), .rst(rst),
    .mode_req(mode_req), .mode_data(mode_data), .mode_ack(mode_ack),
    .dir_req(dir_req), .dir_data(dir_data), .dir_ack(dir_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: bytes still owed by the current frame, expected acks, frame count
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  logic [7:0] exp_frames;
  logic       exp_mack, exp_dack;
  int         last_srv, cur_srv;

  int         m_pend, d_pend;
  logic [7:0] m_next, d_next;
  bit         m_rand, d_rand;
  int         tr_mode, tr_phase;
  logic       prev_stall;
  logic [7:0] prev_data;
  int         busy_cnt, mack_cnt, dack_cnt;
  bit         saw_ff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_frames = 8'h00;
    exp_mack   = 1'b0;
    exp_dack   = 1'b0;
    last_srv   = 1;
    cur_srv    = 1;
    prev_stall = 1'b0;
  endtask

  task automatic step();
    logic [7:0] h, p;
    int serve;
    chk("mode_ack", mode_ack, exp_mack);
    chk("dir_ack", dir_ack, exp_dack);
    chk("tx_valid", tx_valid, exp_q.size() != 0);
    chk("busy", busy, exp_q.size() != 0);
    chk("frames_sent", frames_sent, exp_frames);
    if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q[0]);
    if (prev_stall) chk("stall_hold", tx_data, prev_data);
    if (busy) busy_cnt++;
    if (mode_ack) mack_cnt++;
    if (dir_ack) dack_cnt++;
    if (frames_sent == 8'hFF) saw_ff = 1'b1;

    if (mode_ack) mode_req = 1'b0;
    else if (!mode_req && m_pend > 0) begin
      mode_req  = 1'b1;
      mode_data = m_rand ? 8'($urandom) : m_next;
      m_pend--;
    end
    if (dir_ack) dir_req = 1'b0;
    else if (!dir_req && d_pend > 0) begin
      dir_req  = 1'b1;
      dir_data = d_rand ? 8'($urandom) : d_next;
      d_pend--;
    end

    case (tr_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((tr_phase % 4) == 0) || ((tr_phase % 4) == 3);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    tr_phase++;

    if (tx_valid && tx_ready) log_q.push_back(tx_data);
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;

    exp_mack = 1'b0;
    exp_dack = 1'b0;
    if (exp_q.size() != 0) begin
      if (tx_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          exp_frames = exp_frames + 8'd1;
          last_srv   = cur_srv;
        end
      end
    end else if (mode_req || dir_req) begin
      if (mode_req && dir_req) serve = 1 - last_srv;
      else                     serve = mode_req ? 0 : 1;
      h = (serve == 0) ? 8'hA1 : 8'hA2;
      p = (serve == 0) ? mode_data : dir_data;
      exp_q.push_back(h);
      exp_q.push_back(p);
      exp_q.push_back(h ^ p);
      cur_srv = serve;
      if (serve == 0) exp_mack = 1'b1;
      else            exp_dack = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int max);
    int k = 0;
    while (!(exp_q.size() == 0 && m_pend == 0 && d_pend == 0 && !mode_req && !dir_req) && k < max) begin
      step();
      k++;
    end
    chk("idle_timeout", k < max, 1);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode_req = 1'b0;
    dir_req  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    m_pend = 0; d_pend = 0; m_rand = 0; d_rand = 0;
    m_next = 8'h00; d_next = 8'h00;
    tr_mode = 0; tr_phase = 0;
    busy_cnt = 0; mack_cnt = 0; dack_cnt = 0; saw_ff = 0;
    model_reset();

    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 8'h00);
    chk("rst_acks", {mode_ack, dir_ack}, 2'b00);
    rst = 1'b0;

    // single mode frame
    log_q.delete(); busy_cnt = 0; mack_cnt = 0;
    m_pend = 1; m_next = 8'h02;
    run_until_idle(50);
    chk("t1_len", log_q.size(), 3);
    chk("t1_b0", log_q[0], 8'hA1);
    chk("t1_b1", log_q[1], 8'h02);
    chk("t1_b2", log_q[2], 8'hA3);
    chk("t1_frames", frames_sent, 8'd1);
    chk("t1_busy_cycles", busy_cnt, 3);
    chk("t1_ack_cycles", mack_cnt, 1);

    // simultaneous requests after reset: MODE first
    do_reset();
    log_q.delete(); dack_cnt = 0;
    m_pend = 1; m_next = 8'h01;
    d_pend = 1; d_next = 8'h03;
    run_until_idle(60);
    chk("t2_len", log_q.size(), 6);
    chk("t2_b0", log_q[0], 8'hA1);
    chk("t2_b2", log_q[2], 8'hA0);
    chk("t2_b3", log_q[3], 8'hA2);
    chk("t2_b4", log_q[4], 8'h03);
    chk("t2_b5", log_q[5], 8'hA1);
    chk("t2_frames", frames_sent, 8'd2);
    chk("t2_dack_cycles", dack_cnt, 1);

    // continuous contention alternates headers
    log_q.delete();
    m_pend = 3; d_pend = 3; m_rand = 1; d_rand = 1;
    run_until_idle(100);
    chk("t3_len", log_q.size(), 18);
    for (int i = 0; i < 6; i++) begin
      chk("t3_hdr", log_q[3*i], (i % 2 == 0) ? 8'hA1 : 8'hA2);
      chk("t3_csum", log_q[3*i+2], log_q[3*i] ^ log_q[3*i+1]);
    end

    // backpressure pattern 1,0,0,1
    log_q.delete();
    tr_mode = 1; tr_phase = 0;
    m_pend = 1; d_pend = 1;
    run_until_idle(100);
    chk("t4_len", log_q.size(), 6);
    for (int i = 0; i < 2; i++)
      chk("t4_csum", log_q[3*i+2], log_q[3*i] ^ log_q[3*i+1]);

    // asynchronous reset after payload byte
    tr_mode = 0; m_rand = 0; d_rand = 0;
    log_q.delete();
    m_pend = 1; m_next = 8'h55;
    for (int k = 0; k < 20 && log_q.size() < 2; k++) step();
    chk("t5_reached_payload", log_q.size(), 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", tx_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_frames", frames_sent, 8'h00);
    model_reset();
    mode_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step();
    chk("t5_no_chk_byte", log_q.size(), 2);
    m_pend = 1; m_next = 8'h66;
    run_until_idle(50);
    chk("t5_len", log_q.size(), 5);
    chk("t5_b2", log_q[2], 8'hA1);
    chk("t5_b3", log_q[3], 8'h66);
    chk("t5_b4", log_q[4], 8'hC7);
    chk("t5_frames", frames_sent, 8'd1);

    // 256 DIR frames wrap the counter
    do_reset();
    saw_ff = 0;
    d_pend = 256; d_rand = 1;
    run_until_idle(2000);
    chk("t6_saw_ff", saw_ff, 1);
    chk("t6_wrap", frames_sent, 8'h00);

    // random traffic and backpressure
    m_rand = 1; d_rand = 1; tr_mode = 2;
    for (int k = 0; k < 600; k++) begin
      if (m_pend == 0 && $urandom_range(0, 7) == 0) m_pend = 1;
      if (d_pend == 0 && $urandom_range(0, 7) == 0) d_pend = 1;
      step();
    end
    run_until_idle(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
